extmem_buffer_loader: RTL
=========================

Name: extmem_buffer_loader

Overview:
- DMA-style load engine between the external memory interface and a memory_buffer mode-0 write port.
- Fetches a programmed run of 32-bit external words and unpacks each word into two WID_RAM-wide buffer writes, low half first.
- Writes go to the selected PE banks.
- Sits upstream of first_buffer_module/second_buffer_module; the controller issues the descriptor and owns buffer mode selection.

Parameters:
N_PE, 8, number of PE banks; width of m0_w_en and bank_mask.
ADDR_RAM, 10, buffer address width.
WID_RAM, 16, buffer word width; fixed at 16 so one external word is exactly two buffer words.
RD_LAT, 2, external read latency in cycles (legal range 1..4).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  descriptor strobe; sampled only in IDLE
abort  in  1  cancel current transfer
ext_base  in  24  first external word address
n_words  in  16  number of 32-bit external words to transfer
buf_base  in  ADDR_RAM  first buffer address
bank_mask  in  N_PE  PE bank write enables (multiple bits = broadcast)
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
re_extmem  out  1  external read strobe
rd_addr_extmem  out  24  external read address
data_rd_extmem  in  32  external read data
m0_w_en  out  N_PE  buffer bank write enables
m0_w_addr  out  ADDR_RAM  buffer write address
m0_w_data  out  WID_RAM  buffer write data

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; all internal pointers, counters and hold registers 0.
- Outputs are Moore, decoded from registered state and registered pointers.
- States: IDLE, REQ, WAIT, WR_LO, WR_HI, DONE.
- IDLE:
  - On start=1, latch ext_base→ext_ptr, buf_base→buf_ptr, bank_mask→mask_q, n_words→remaining.
  - Go to DONE if n_words==0, else to REQ.
  - busy=0 in IDLE; busy=1 in every other state, including DONE.
- REQ (1 cycle): re_extmem=1, rd_addr_extmem=ext_ptr. Go to WAIT.
- WAIT (RD_LAT cycles, counted by wait_cnt):
  - data_rd_extmem is valid in the RD_LAT-th cycle after REQ; capture it into hold in that cycle.
  - Then go to WR_LO.
- WR_LO (1 cycle): m0_w_en=mask_q, m0_w_addr=buf_ptr, m0_w_data=hold[15:0]; buf_ptr+=1.
- WR_HI (1 cycle): m0_w_en=mask_q, m0_w_addr=buf_ptr, m0_w_data=hold[31:16]; buf_ptr+=1; ext_ptr+=1; remaining-=1.
  - Go to REQ if remaining (before decrement) > 1, else to DONE.
- DONE (1 cycle): done=1. Go to IDLE.
- Throughput: 3+RD_LAT cycles per external word. Total cycles from start sample to done = n_words*(3+RD_LAT)+1.
- m0_w_en, m0_w_addr and m0_w_data are 0 outside WR_LO/WR_HI. rd_addr_extmem is 0 outside REQ.
- Wrap-around:
  - buf_ptr wraps modulo 2^ADDR_RAM silently.
  - ext_ptr wraps modulo 2^24 silently.
- bank_mask==0: external reads still occur; no buffer writes; done still pulses.
- start while busy: ignored; the descriptor is not queued.
- abort=1 in any non-IDLE state: next state is IDLE, no done pulse, pointers discarded.
  - Any write or read strobe already presented in the abort cycle stands.
  - abort in IDLE has no effect.
- start and abort both high in IDLE: abort ignored, start accepted.
- n_words=16'hFFFF is legal; no overflow because remaining is 16-bit and decrements to 0.
- we_extmem/wr_addr_extmem/data_wr_extmem are not driven by this block.

Test Plan:
- Single word, RD_LAT=2:
  - Stimulus: start with ext_base=0x000100, n_words=1, buf_base=0x010, bank_mask=8'b0000_0100; memory returns 0xBEEF_1234.
  - Response: re_extmem pulse with addr 0x000100; write 0x1234@0x010 then 0xBEEF@0x011 on bank 2 only; done 6 cycles after start sample; busy falls with done.
- Burst with broadcast:
  - Stimulus: n_words=4, ext_base=0x0000F0, buf_base=0, bank_mask=8'hFF, data = address.
  - Response: 4 reads at 0xF0..0xF3; 8 writes, addresses 0..7, data sequence 0x00F0,0x0000,0x00F1,0x0000,…; all enables 8'hFF; done at cycle 21.
- Wrap-around:
  - Stimulus: buf_base=0x3FF, ext_base=0xFFFFFF, n_words=2.
  - Response: writes at 0x3FF,0x000,0x001,0x002; second read address 0x000000.
- Zero length and no-bank:
  - Stimulus: n_words=0.
  - Response: no re_extmem or m0_w_en activity; done pulse exactly 1 cycle after start; busy high for that 1 cycle.
  - Stimulus: bank_mask=0, n_words=1.
  - Response: one read, no writes, done pulses.
- Abort and restart:
  - Stimulus: abort in the WAIT state of word 2 of n_words=3.
  - Response: IDLE next cycle; no done; only 2 buffer writes occurred.
  - Stimulus: new start with n_words=1.
  - Response: completes normally using the new descriptor.
- Async reset mid-transfer:
  - Stimulus: drop rst between clock edges during WR_LO.
  - Response: all outputs 0 immediately, without waiting for a clock edge; after release, start is accepted and runs cleanly.
  - Stimulus: start pulsed while busy.
  - Response: the start is ignored.

Source files
------------

// File: rtl/extmem_buffer_loader.sv
// Load engine: fetches a run of 32-bit external words and writes each one as two
// WID_RAM-wide words (low half first) into the selected memory_buffer PE banks.
module extmem_buffer_loader #(
    parameter int N_PE     = 8,
    parameter int ADDR_RAM = 10,
    parameter int WID_RAM  = 16,
    parameter int RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [23:0]         ext_base,
    input  logic [15:0]         n_words,
    input  logic [ADDR_RAM-1:0] buf_base,
    input  logic [N_PE-1:0]     bank_mask,
    output logic                busy,
    output logic                done,
    output logic                re_extmem,
    output logic [23:0]         rd_addr_extmem,
    input  logic [31:0]         data_rd_extmem,
    output logic [N_PE-1:0]     m0_w_en,
    output logic [ADDR_RAM-1:0] m0_w_addr,
    output logic [WID_RAM-1:0]  m0_w_data
);

    // Handshake: start is a one-cycle descriptor strobe honoured only while busy=0;
    // the transfer ends with a one-cycle done pulse, after which busy drops.
    // Read data is not acknowledged: it is taken RD_LAT cycles after re_extmem.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [23:0]         ext_ptr;
    logic [ADDR_RAM-1:0] buf_ptr;
    logic [N_PE-1:0]     mask_q;
    logic [15:0]         remaining;
    logic [2:0]          wait_cnt;
    logic [31:0]         hold;

    // Outputs are loaded on the transition into the state that presents them,
    // so buf_ptr already points past the word currently on m0_w_addr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ext_ptr        <= '0;
            buf_ptr        <= '0;
            mask_q         <= '0;
            remaining      <= '0;
            wait_cnt       <= '0;
            hold           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            re_extmem      <= 1'b0;
            rd_addr_extmem <= '0;
            m0_w_en        <= '0;
            m0_w_addr      <= '0;
            m0_w_data      <= '0;
        end else begin
            done           <= 1'b0;
            re_extmem      <= 1'b0;
            rd_addr_extmem <= '0;
            m0_w_en        <= '0;
            m0_w_addr      <= '0;
            m0_w_data      <= '0;
            if (abort && state != IDLE) begin
                state     <= IDLE;
                busy      <= 1'b0;
                ext_ptr   <= '0;
                buf_ptr   <= '0;
                mask_q    <= '0;
                remaining <= '0;
                wait_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            ext_ptr   <= ext_base;
                            buf_ptr   <= buf_base;
                            mask_q    <= bank_mask;
                            remaining <= n_words;
                            busy      <= 1'b1;
                            if (n_words == 16'd0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state          <= REQ;
                                re_extmem      <= 1'b1;
                                rd_addr_extmem <= ext_base;
                            end
                        end
                    end
                    REQ: begin
                        state    <= WAIT;
                        wait_cnt <= 3'd1;
                    end
                    WAIT: begin
                        if (wait_cnt == 3'(RD_LAT)) begin
                            state     <= WR_LO;
                            hold      <= data_rd_extmem;
                            m0_w_en   <= mask_q;
                            m0_w_addr <= buf_ptr;
                            m0_w_data <= data_rd_extmem[WID_RAM-1:0];
                            buf_ptr   <= buf_ptr + 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 3'd1;
                        end
                    end
                    WR_LO: begin
                        state     <= WR_HI;
                        m0_w_en   <= mask_q;
                        m0_w_addr <= buf_ptr;
                        m0_w_data <= hold[2*WID_RAM-1:WID_RAM];
                        buf_ptr   <= buf_ptr + 1'b1;
                    end
                    WR_HI: begin
                        ext_ptr   <= ext_ptr + 24'd1;
                        remaining <= remaining - 16'd1;
                        if (remaining > 16'd1) begin
                            state          <= REQ;
                            re_extmem      <= 1'b1;
                            rd_addr_extmem <= ext_ptr + 24'd1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
